// File: rtl/led_arb_pkg.sv
// Shared types and default constants for the LED bank arbiter.
package led_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned WIDTH_DEF = 5;
    localparam int unsigned DWELL_DEF = 4194304;

    // Short dwell used by simulation so rotations happen in a handful of cycles.
    localparam int unsigned DWELL_SIM = 4;

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// Rotating priority encoder: finds the first requesting, non-excluded source
// searching upward from ptr+1 and wrapping modulo NREQ.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic [NREQ-1:0] excl,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   index,
    output logic            any
);

    logic [NREQ-1:0] cand;
    int unsigned     idx;

    assign cand = req & ~excl;

    // Walk NREQ positions starting just after ptr; the first candidate wins.
    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!any && cand[idx]) begin
                any         = 1'b1;
                index       = IW'(idx);
                onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing the LED bank between NREQ pattern sources,
// with a minimum dwell per grant and registered outputs only.
// Optional feature macro: LED_ARB_PRIO_EN (source 0 preempts and holds
// while requesting; the rr pointer is not moved by source-0 grants).
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DWELL = DWELL_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] pat,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      leds,
    output logic                  busy,
    output logic                  swp
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DWELL - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  leds_q, leds_d;
    logic              busy_q, busy_d;
    logic              swp_q, swp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     cur_q, cur_d;

    logic [NREQ-1:0]   pk_onehot;
    logic [IW-1:0]     pk_index;
    logic              pk_any;
    logic [CW-1:0]     cnt_dec;
    logic [WIDTH-1:0]  cur_pat;

    // gnt_q is the one-hot of the current holder (zero when idle), so it
    // doubles as the exclusion mask for re-arbitration.
    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .excl   (gnt_q),
        .onehot (pk_onehot),
        .index  (pk_index),
        .any    (pk_any)
    );

    assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    assign cur_pat = pat[cur_q*WIDTH +: WIDTH];

    // Next-state, grant, dwell counter, pointer and LED drive.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        swp_d   = 1'b0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        leds_d  = (state_q == ST_HOLD) ? cur_pat : '0;

        case (state_q)
            ST_IDLE: begin
`ifdef LED_ARB_PRIO_EN
                if (req[0]) begin
                    state_d  = ST_HOLD;
                    gnt_d    = '0;
                    gnt_d[0] = 1'b1;
                    cur_d    = '0;
                    busy_d   = 1'b1;
                    swp_d    = 1'b1;
                    cnt_d    = CNT_RELOAD;
                end else
`endif
                if (pk_any) begin
                    state_d = ST_HOLD;
                    gnt_d   = pk_onehot;
                    cur_d   = pk_index;
                    ptr_d   = pk_index;
                    busy_d  = 1'b1;
                    swp_d   = 1'b1;
                    cnt_d   = CNT_RELOAD;
                end
            end

            ST_HOLD: begin
`ifdef LED_ARB_PRIO_EN
                if (req[0] && (cur_q != '0)) begin
                    gnt_d    = '0;
                    gnt_d[0] = 1'b1;
                    cur_d    = '0;
                    swp_d    = 1'b1;
                    cnt_d    = CNT_RELOAD;
                end else
`endif
                if (!req[cur_q]) begin
                    if (pk_any) begin
                        gnt_d = pk_onehot;
                        cur_d = pk_index;
                        ptr_d = pk_index;
                        swp_d = 1'b1;
                        cnt_d = CNT_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        leds_d  = '0;
                        cnt_d   = '0;
                    end
                end
`ifdef LED_ARB_PRIO_EN
                else if (cur_q == '0) begin
                    cnt_d = cnt_dec;
                end
`endif
                else if (cnt_q == '0) begin
                    if (pk_any) begin
                        gnt_d = pk_onehot;
                        cur_d = pk_index;
                        ptr_d = pk_index;
                        swp_d = 1'b1;
                    end
                    cnt_d = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                leds_d  = '0;
            end
        endcase
    end

    // State register; reset starts the pointer at NREQ-1 so the first search begins at 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            swp_q   <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
            swp_q   <= swp_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
        end
    end

    assign gnt  = gnt_q;
    assign leds = leds_q;
    assign busy = busy_q;
    assign swp  = swp_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter: stimulus queues expected grants,
// a negedge monitor checks them on every swp pulse.
module tb_led_bank_arbiter;
    import led_arb_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 5;
    localparam int unsigned D = DWELL_SIM;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [N*W-1:0] pat;
    logic [N-1:0]   gnt;
    logic [W-1:0]   leds;
    logic           busy;
    logic           swp;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] leds;
        int           len;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_bank_arbiter #(
        .NREQ  (N),
        .WIDTH (W),
        .DWELL (D)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .pat    (pat),
        .gnt    (gnt),
        .leds   (leds),
        .busy   (busy),
        .swp    (swp)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Source patterns: 0=00011 1=01100 2=10101 3=11110
    function automatic logic [W-1:0] pof(input int i);
        case (i)
            0: return 5'b00011;
            1: return 5'b01100;
            2: return 5'b10101;
            default: return 5'b11110;
        endcase
    endfunction

    task automatic expect_grant(input int idx, input int len);
        exp_t e;
        e.gnt      = '0;
        e.gnt[idx] = 1'b1;
        e.leds     = pof(idx);
        e.len      = len;
        sbq.push_back(e);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 0);
        chk({nm, "_leds"}, 32'(leds), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        req    = '0;
        @(negedge clk);
        chk_idle("reset");
        chk("reset_swp", 32'(swp), 0);
        resetn = 1'b1;
    endtask

    // Monitor: pop one expectation per swp pulse; check leds one cycle later.
    initial begin
        int           since;
        bit           lp;
        logic [W-1:0] le;
        exp_t         e;
        since = 0;
        lp    = 0;
        le    = '0;
        forever begin
            @(negedge clk);
            since++;
            if (lp) begin
                chk("leds_after_grant", 32'(leds), 32'(le));
                lp = 0;
            end
            if (swp === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_swp: got gnt=%b expected no grant change at %0t", gnt, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("gnt_on_swp", 32'(gnt), 32'(e.gnt));
                    chk("busy_on_swp", 32'(busy), 1);
                    if (e.len != 0) chk("grant_len", since, e.len);
                    le = e.leds;
                    lp = 1;
                end
                since = 0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        pat    = {5'b11110, 5'b10101, 5'b01100, 5'b00011};
        req    = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("por");
        resetn = 1'b1;

        // 1: idle with no requests
        repeat (20) begin
            @(negedge clk);
            chk_idle("idle20");
        end

        // 2: single requester holds indefinitely
        @(negedge clk);
        req = 4'b0100;
        expect_grant(2, 0);
        repeat (14) @(negedge clk);
        chk("hold_gnt", 32'(gnt), 32'(4'b0100));
        chk("hold_busy", 32'(busy), 1);
        chk("hold_leds", 32'(leds), 32'(5'b10101));
        req = '0;
        repeat (2) @(negedge clk);
        chk_idle("release2");

        // 3: all requesting, rotation 0,1,2,3,0 with 4-cycle grants
        do_reset();
        @(negedge clk);
        req = 4'b1111;
        expect_grant(0, 0);
        expect_grant(1, 4);
        expect_grant(2, 4);
        expect_grant(3, 4);
        expect_grant(0, 4);
        repeat (18) @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        chk_idle("release3");

        // 4: early release chains to the other requester, then idle
        do_reset();
        @(negedge clk);
        req = 4'b0011;
        expect_grant(0, 0);
        expect_grant(1, 2);
        repeat (2) @(negedge clk);
        req = 4'b0010;
        repeat (3) @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        chk_idle("release4");

        // 5: asynchronous reset mid-grant, then lowest requester first
        do_reset();
        @(negedge clk);
        req = 4'b0110;
        expect_grant(1, 0);
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_swp", 32'(swp), 0);
        @(negedge clk);
        resetn = 1'b1;
        expect_grant(1, 0);
        repeat (4) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        chk_idle("release5");

`ifdef LED_ARB_PRIO_EN
        // 6: source 0 preempts, holds past dwell, rotation resumes at 3
        do_reset();
        @(negedge clk);
        req = 4'b0100;
        expect_grant(2, 0);
        @(negedge clk);
        req = 4'b1101;
        expect_grant(0, 1);
        repeat (11) @(negedge clk);
        chk("prio_hold_gnt", 32'(gnt), 32'(4'b0001));
        req = 4'b1100;
        expect_grant(3, 0);
        repeat (3) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        chk_idle("release6");
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
